qmult_seq: RTL and testbench



---
 rtl/qmult_seq_if.sv | 24 ++
 rtl/qmult_seq.sv | 161 ++++++++++++++++
 tb/tb_qmult_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/qmult_seq_if.sv
// Operand/result handshake bundle for the sequential fixed-point multiplier.
// The producer/consumer side uses master and the multiplier uses slave.
interface qmult_seq_if #(
    parameter int N = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] o_result;
    logic         ovr;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, o_result, ovr
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, o_result, ovr
    );
endinterface

// File: rtl/qmult_seq.sv
// Sequential signed QN fixed-point multiplier: sign/magnitude shift-add core,
// then optional half-up rounding on the magnitude and saturation on overflow.
module qmult_seq #(
    parameter int Q     = 18,
    parameter int N     = 32,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input logic        clk,
    input logic        rst,
    qmult_seq_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(N + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_RND  = CW'(N);
    localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  RND_C    = (ROUND != 0 && Q > 0) ?
                                         (ONE_W << ((Q > 0) ? (Q - 1) : 0)) : {W{1'b0}};
    localparam logic [W-1:0]  POS_LIM  = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [W-1:0]  NEG_LIM  = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  MAX_R    = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MIN_R    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};

    // |-2^(N-1)| wraps to 2^(N-1), which is exactly right as an unsigned magnitude.
    function automatic logic [N-1:0] mag_f(input logic [N-1:0] v);
        mag_f = v[N-1] ? (~v + ONE_N) : v;
    endfunction

    state_t        state_q, state_d;
    logic          sign_q, sign_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  res_q, res_d;
    logic          ovr_q, ovr_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [W-1:0]  m_s;
    logic [N-1:0]  mlo_s;
    logic          ovf_s;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.o_result  = res_q;
    assign bus.ovr       = ovr_q;

    // Next-state and datapath; FINAL spends one cycle on the rounding add, one on the result.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        ovr_d       = ovr_q;
        out_valid_d = 1'b0;

        m_s   = acc_q >> Q;
        mlo_s = m_s[N-1:0];
        ovf_s = sign_q ? (m_s > NEG_LIM) : (m_s > POS_LIM);

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sign_d   = bus.a[N-1] ^ bus.b[N-1];
                    mcand_d  = {{N{1'b0}}, mag_f(bus.a)};
                    mplier_d = mag_f(bus.b);
                    acc_d    = {W{1'b0}};
                    cnt_d    = {CW{1'b0}};
                    state_d  = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FINAL;
                end else begin
                    state_d = CALC;
                end
            end
            FINAL: begin
                if (cnt_q == CNT_RND) begin
                    acc_d = acc_q + RND_C;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    ovr_d = ovf_s;
                    if (ovf_s && (SAT != 0)) begin
                        res_d = sign_q ? MIN_R : MAX_R;
                    end else begin
                        res_d = sign_q ? (~mlo_s + ONE_N) : mlo_s;
                    end
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mcand_q     <= {W{1'b0}};
            mplier_q    <= {N{1'b0}};
            acc_q       <= {W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            res_q       <= {N{1'b0}};
            ovr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            ovr_q       <= ovr_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_qmult_seq.sv
// Directed bench for qmult_seq: three parameter variants driven in lockstep,
// checked against a native-multiply reference through per-variant queues.
module tb_qmult_seq;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [32:0] q_m[$];
    logic [32:0] q_s[$];
    logic [32:0] q_t[$];

    qmult_seq_if #(.N(32)) im ();
    qmult_seq_if #(.N(32)) is ();
    qmult_seq_if #(.N(32)) it ();

    qmult_seq #(.Q(18), .N(32), .ROUND(1), .SAT(1)) u_main  (.clk(clk), .rst(rst), .bus(im));
    qmult_seq #(.Q(18), .N(32), .ROUND(1), .SAT(0)) u_nosat (.clk(clk), .rst(rst), .bus(is));
    qmult_seq #(.Q(18), .N(32), .ROUND(0), .SAT(1)) u_trunc (.clk(clk), .rst(rst), .bus(it));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference: full signed product, then magnitude rounding, shift and range check.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input bit rnd, input bit sat);
        longint pa, pb, prod, mag, m;
        bit neg, ovf;
        logic [31:0] r;
        pa   = longint'($signed(a));
        pb   = longint'($signed(b));
        prod = pa * pb;
        neg  = (prod < 64'sd0);
        mag  = neg ? -prod : prod;
        if (rnd) mag = mag + 64'sd131072;
        m   = mag >>> 18;
        ovf = neg ? (m > 64'sh80000000) : (m > 64'sh7FFFFFFF);
        if (sat && ovf) begin
            r = neg ? 32'h80000000 : 32'h7FFFFFFF;
        end else begin
            m = neg ? -m : m;
            r = m[31:0];
        end
        return {ovf, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
        im.in_valid = v; is.in_valid = v; it.in_valid = v;
        im.a = a; is.a = a; it.a = a;
        im.b = b; is.b = b; it.b = b;
    endtask

    task automatic set_ready(input logic r);
        im.out_ready = r; is.out_ready = r; it.out_ready = r;
    endtask

    task automatic quiet(input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (im.out_valid || is.out_valid || it.out_valid) seen++;
        end
        chk("no_spurious_valid", 32'(seen), 32'd0);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input int hold, input bit chk_lat);
        int guard;
        int lat;
        logic [32:0] em, es, et;
        guard = 0;
        @(negedge clk);
        while (im.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_wait", 32'(im.in_ready), 32'd1);
        drive(1'b1, a, b);
        set_ready(hold == 0);
        q_m.push_back(model(a, b, 1'b1, 1'b1));
        q_s.push_back(model(a, b, 1'b1, 1'b0));
        q_t.push_back(model(a, b, 1'b0, 1'b1));
        @(posedge clk); #1;
        drive(1'b0, $urandom(), $urandom());
        chk("busy_in_ready", 32'(im.in_ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (im.out_valid !== 1'b1 && lat < 100);
        if (chk_lat) chk("latency", 32'(lat), 32'd34);
        chk("valid_main", 32'(im.out_valid), 32'd1);
        chk("valid_nosat", 32'(is.out_valid), 32'd1);
        chk("valid_trunc", 32'(it.out_valid), 32'd1);
        chk("done_in_ready", 32'(im.in_ready), 32'd0);
        em = (q_m.size() > 0) ? q_m.pop_front() : 33'd0;
        es = (q_s.size() > 0) ? q_s.pop_front() : 33'd0;
        et = (q_t.size() > 0) ? q_t.pop_front() : 33'd0;
        chk("res_main", im.o_result, em[31:0]);
        chk("ovr_main", 32'(im.ovr), 32'(em[32]));
        chk("res_nosat", is.o_result, es[31:0]);
        chk("ovr_nosat", 32'(is.ovr), 32'(es[32]));
        chk("res_trunc", it.o_result, et[31:0]);
        chk("ovr_trunc", 32'(it.ovr), 32'(et[32]));
        for (int i = 0; i < hold; i++) begin
            if (i == 2) drive(1'b1, 32'h00040000, 32'h00040000);
            @(posedge clk); #1;
            drive(1'b0, $urandom(), $urandom());
            chk("hold_res", im.o_result, em[31:0]);
            chk("hold_ovr", 32'(im.ovr), 32'(em[32]));
            chk("hold_valid", 32'(im.out_valid), 32'd1);
            chk("hold_in_ready", 32'(im.in_ready), 32'd0);
        end
        set_ready(1'b1);
        @(posedge clk); #1;
        chk("valid_drop", 32'(im.out_valid), 32'd0);
        chk("post_in_ready", 32'(im.in_ready), 32'd1);
        chk("res_kept", im.o_result, em[31:0]);
    endtask

    // Directed sequence: reset, test-plan vectors, flow control, abort, random operands.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(im.in_ready), 32'd0);
        chk("rst_out_valid", 32'(im.out_valid), 32'd0);
        chk("rst_result", im.o_result, 32'd0);
        chk("rst_ovr", 32'(im.ovr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(im.in_ready), 32'd1);

        send(32'h00060000, 32'h00080000, 0, 1'b1);
        send(32'hFFFA0000, 32'h00080000, 0, 1'b1);
        send(32'hFFFA0000, 32'hFFFA0000, 0, 1'b0);
        send(32'h01900000, 32'h01900000, 0, 1'b0);
        send(32'hFE700000, 32'h01900000, 0, 1'b0);
        send(32'h80000000, 32'h00040000, 0, 1'b0);
        send(32'h80000000, 32'hFFFC0000, 0, 1'b0);
        send(32'h00000001, 32'h00020000, 0, 1'b0);
        send(32'hFFFFFFFF, 32'h00020000, 0, 1'b0);
        send(32'h00000000, 32'hFFFC0000, 0, 1'b0);

        send(32'h00060000, 32'hFFFA0000, 5, 1'b0);
        quiet(10);

        @(negedge clk);
        drive(1'b1, 32'h00060000, 32'h00080000);
        @(posedge clk); #1;
        drive(1'b0, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 32'(im.out_valid), 32'd0);
        chk("abort_result", im.o_result, 32'd0);
        chk("abort_ovr", 32'(im.ovr), 32'd0);
        chk("abort_in_ready", 32'(im.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_rel_ready", 32'(im.in_ready), 32'd1);
        quiet(40);
        send(32'h00060000, 32'h00080000, 0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            send($urandom(), $urandom(), 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            ra = {{8{i[0]}}, 24'($urandom())};
            rb = {{8{i[1]}}, 24'($urandom())};
            send(ra, rb, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
